// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: parametrised floating-point add/sub, round-to-nearest-even, exception flags.
// Latency: 3 register stages (S1 align, S2 add/normalise, S3 round/output), 1 op per cycle.
// Backpressure: in_ready = ~out_valid | out_ready; a stalled output freezes every stage.
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 4;           // hidden + fraction + guard/round/sticky
  localparam int EW2  = EXP_W + 2;           // signed working exponent
  localparam int RW   = MAN_W + 2;           // rounded significand with carry
  localparam int LZ_W = $clog2(SW + 1);

  localparam logic [W-1:0]           QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW2-1:0]  EXP_MAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0]  EXP_ZERO = '0;

  // Position of the highest set bit, counted from the MSB; SW when v is zero.
  function automatic logic [LZ_W-1:0] lzc(input logic [SW-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) n = LZ_W'(SW - 1 - i);
    end
    return n;
  endfunction

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb, e_big, e_sml, ediff;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [W-2:0]       key_a, key_b;
  logic [SW-1:0]      ma, mb, m_big, m_sml, m_aln;
  logic               swap;
  logic [31:0]        shamt;

  assign sa     = op_a[W-1];
  assign sb     = op_b[W-1] ^ op_sub;
  assign ea     = op_a[W-2:MAN_W];
  assign eb     = op_b[W-2:MAN_W];
  assign fa     = op_a[MAN_W-1:0];
  assign fb     = op_b[MAN_W-1:0];
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);
  // Subnormals are flushed: a zero exponent contributes neither magnitude nor hidden bit.
  assign key_a  = a_zero ? '0 : {ea, fa};
  assign key_b  = b_zero ? '0 : {eb, fb};
  assign ma     = a_zero ? '0 : {1'b1, fa, 3'b000};
  assign mb     = b_zero ? '0 : {1'b1, fb, 3'b000};

  logic               s1_spec_d, s1_spec_q;
  logic [W-1:0]       s1_spec_res_d, s1_spec_res_q;
  logic [3:0]         s1_spec_flg_d, s1_spec_flg_q;
  logic               s1_vld_q, s1_sign_q, s1_zsign_q, s1_sub_q;
  logic [EXP_W-1:0]   s1_exp_q;
  logic [SW-1:0]      s1_ma_q, s1_mb_q;

  // Inf/NaN operands bypass the arithmetic with a fixed result.
  always_comb begin
    s1_spec_d     = 1'b0;
    s1_spec_res_d = '0;
    s1_spec_flg_d = '0;
    if (a_nan || b_nan) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = QNAN;
    end else if (a_inf && b_inf && (sa ^ sb)) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = QNAN;
      s1_spec_flg_d = 4'b1000;
    end else if (a_inf) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // Larger magnitude goes to A; B is shifted right with lost bits folded into sticky.
  always_comb begin
    swap  = key_b > key_a;
    e_big = swap ? eb : ea;
    e_sml = swap ? ea : eb;
    m_big = swap ? mb : ma;
    m_sml = swap ? ma : mb;
    ediff = e_big - e_sml;
    shamt = 32'(ediff);
    if (shamt >= 32'(MAN_W + 3)) begin
      m_aln = {{(SW-1){1'b0}}, |m_sml};
    end else begin
      m_aln = (m_sml >> shamt) | {{(SW-1){1'b0}}, |(m_sml & ~({SW{1'b1}} << shamt))};
    end
  end

  // Stage 1 register; advances only when the output can move.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_vld_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_spec_res_q <= '0;
      s1_spec_flg_q <= '0;
      s1_sign_q     <= 1'b0;
      s1_zsign_q    <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_exp_q      <= '0;
      s1_ma_q       <= '0;
      s1_mb_q       <= '0;
    end else if (advance) begin
      s1_vld_q      <= in_valid;
      s1_spec_q     <= s1_spec_d;
      s1_spec_res_q <= s1_spec_res_d;
      s1_spec_flg_q <= s1_spec_flg_d;
      s1_sign_q     <= swap ? sb : sa;
      s1_zsign_q    <= sa & sb;      // only (-0)+(-0) keeps a negative zero
      s1_sub_q      <= sa ^ sb;
      s1_exp_q      <= e_big;
      s1_ma_q       <= m_big;
      s1_mb_q       <= m_aln;
    end
  end

  // ---------------- S2: add/sub and normalise ----------------
  logic [SW:0]            sum;
  logic [LZ_W-1:0]        lz;
  logic [EW2-1:0]         exp_ext;
  logic [SW-1:0]          s2_man_d, s2_man_q;
  logic signed [EW2-1:0]  s2_exp_d, s2_exp_q;
  logic                   s2_vld_q, s2_spec_q, s2_sign_q, s2_zsign_q, s2_zero_q;
  logic [W-1:0]           s2_spec_res_q;
  logic [3:0]             s2_spec_flg_q;

  assign sum     = s1_sub_q ? ({1'b0, s1_ma_q} - {1'b0, s1_mb_q})
                            : ({1'b0, s1_ma_q} + {1'b0, s1_mb_q});
  assign lz      = lzc(sum[SW-1:0]);
  assign exp_ext = {2'b00, s1_exp_q};

  // Carry-out renormalises right by one; otherwise shift left by the leading-zero count.
  always_comb begin
    s2_man_d = '0;
    s2_exp_d = '0;
    if (sum[SW]) begin
      s2_man_d = {sum[SW:2], sum[1] | sum[0]};
      s2_exp_d = exp_ext + EW2'(1);
    end else begin
      s2_man_d = sum[SW-1:0] << lz;
      s2_exp_d = exp_ext - EW2'(lz);
    end
  end

  // Stage 2 register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_vld_q      <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_spec_res_q <= '0;
      s2_spec_flg_q <= '0;
      s2_sign_q     <= 1'b0;
      s2_zsign_q    <= 1'b0;
      s2_zero_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_man_q      <= '0;
    end else if (advance) begin
      s2_vld_q      <= s1_vld_q;
      s2_spec_q     <= s1_spec_q;
      s2_spec_res_q <= s1_spec_res_q;
      s2_spec_flg_q <= s1_spec_flg_q;
      s2_sign_q     <= s1_sign_q;
      s2_zsign_q    <= s1_zsign_q;
      s2_zero_q     <= ~(|sum);
      s2_exp_q      <= s2_exp_d;
      s2_man_q      <= s2_man_d;
    end
  end

  // ---------------- S3: round, range check, pack ----------------
  logic                   g_bit, r_bit, s_bit, l_bit, rnd_inc, inexact;
  logic [RW-1:0]          rnd;
  logic signed [EW2-1:0]  exp_r;
  logic [MAN_W-1:0]       frac;
  logic [W-1:0]           result_d, result_q;
  logic [3:0]             flags_d, flags_q;
  logic                   out_vld_q;

  assign l_bit   = s2_man_q[3];
  assign g_bit   = s2_man_q[2];
  assign r_bit   = s2_man_q[1];
  assign s_bit   = s2_man_q[0];
  assign rnd_inc = g_bit & (r_bit | s_bit | l_bit);
  assign inexact = g_bit | r_bit | s_bit;
  assign rnd     = {1'b0, s2_man_q[SW-1:3]} + RW'(rnd_inc);
  assign exp_r   = s2_exp_q + EW2'(rnd[RW-1]);
  assign frac    = rnd[RW-1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

  // Result selection: special operands, exact zero, overflow, underflow, normal.
  always_comb begin
    result_d = '0;
    flags_d  = '0;
    if (s2_spec_q) begin
      result_d = s2_spec_res_q;
      flags_d  = s2_spec_flg_q;
    end else if (s2_zero_q) begin
      result_d = {s2_zsign_q, {(W-1){1'b0}}};
    end else if (exp_r >= EXP_MAX) begin
      result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d  = 4'b0101;
    end else if (exp_r <= EXP_ZERO) begin
      result_d = {s2_sign_q, {(W-1){1'b0}}};
      flags_d  = 4'b0011;
    end else begin
      result_d = {s2_sign_q, exp_r[EXP_W-1:0], frac};
      flags_d  = {3'b000, inexact};
    end
  end

  // Output register; holds while the sink withholds out_ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_vld_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else if (advance) begin
      out_vld_q <= s2_vld_q;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign out_valid = out_vld_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed and randomised checks of fp_addsub_pipe (half precision).
// Expected results come from an exact-integer reference model and a scoreboard queue.
// Backpressure, stall hold, latency and mid-flight reset are exercised explicitly.
module tb_fp_addsub_pipe;

  logic        clock;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clock     (clock),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_chk = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          n_ret = 0;
  logic [19:0] exp_q[$];
  logic        use_dir = 1'b0;
  logic [19:0] dir_val = '0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Exact model: operands become signed integers scaled by 2^-25, summed exactly,
  // then rounded to 11 significant bits with ties to even.
  function automatic logic [19:0] ref_fp(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic   sa, sb, sg, inx;
    int     ea, eb, fa, fb, p, e, sh;
    longint va, vb, s, m, q, rem, half;
    sa = a[15]; sb = b[15] ^ sub;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0)) return {16'h7E00, 4'b0000};
    if (ea == 31 && eb == 31 && sa != sb) return {16'h7E00, 4'b1000};
    if (ea == 31) return {sa, 15'h7C00, 4'b0000};
    if (eb == 31) return {sb, 15'h7C00, 4'b0000};
    va = (ea == 0) ? 64'sd0 : (longint'(1024 + fa) <<< ea);
    vb = (eb == 0) ? 64'sd0 : (longint'(1024 + fb) <<< eb);
    if (sa) va = -va;
    if (sb) vb = -vb;
    s = va + vb;
    if (s == 0) return {sa & sb, 15'h0000, 4'b0000};
    sg = (s < 0);
    m  = sg ? -s : s;
    p  = 0;
    for (int i = 0; i < 63; i++) if (m[i]) p = i;
    e   = p - 10;
    inx = 1'b0;
    if (p > 10) begin
      sh   = p - 10;
      q    = m >>> sh;
      rem  = m - (q <<< sh);
      half = 64'sd1 <<< (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 2048) begin q = 1024; e = e + 1; end
    end else begin
      q = m <<< (10 - p);
    end
    if (e >= 31) return {sg, 15'h7C00, 4'b0101};
    if (e <= 0)  return {sg, 15'h0000, 4'b0011};
    return {sg, 5'(e), 10'(q), 3'b000, inx};
  endfunction

  // Scoreboard: transfers are decided at the falling edge and happen on the next rise.
  always @(negedge clock) begin
    logic [19:0] e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_ret++;
        if (exp_q.size() == 0) begin
          chk_eq("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk_eq("result", 32'(result), 32'(e[19:4]));
          chk_eq("flags", 32'(flags), 32'(e[3:0]));
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        exp_q.push_back(use_dir ? dir_val : ref_fp(op_a, op_b, op_sub));
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk_eq("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_d(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [19:0] want);
    use_dir = 1'b1; dir_val = want;
    send(a, b, s);
    use_dir = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clock);
    repeat (2) @(posedge clock);
    #1;
    chk_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Counts rising edges from the accept edge (counted as 1) to out_valid.
  task automatic lat_chk(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [19:0] want);
    int n;
    use_dir = 1'b1; dir_val = want;
    op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
    @(negedge clock);
    chk_eq("lat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0; use_dir = 1'b0;
    n = 1;
    @(negedge clock);
    while (!out_valid && n < 10) begin
      @(posedge clock); n++;
      @(negedge clock);
    end
    chk_eq("latency", 32'(n), 32'd3);
  endtask

  function automatic logic [15:0] rnd_op(input logic [4:0] near);
    logic [15:0] v;
    int          k;
    v = 16'($urandom);
    k = $urandom_range(0, 15);
    if (k == 0)      v[14:10] = 5'h1f;
    else if (k == 1) v[14:10] = 5'h00;
    else if (k == 2) v[14:10] = 5'h1e;
    else if (k < 10) v[14:10] = near + 5'($urandom_range(0, 3)) - 5'd1;
    return v;
  endfunction

  localparam int DN = 12;
  logic [15:0] d_a [DN] = '{16'h3C00, 16'h3C01, 16'h3C00, 16'hC000, 16'h7BFF, 16'h7C00,
                            16'h7E00, 16'h8000, 16'h0400, 16'h3C00, 16'h3C00, 16'h3C00};
  logic [15:0] d_b [DN] = '{16'h1000, 16'h1000, 16'h3C00, 16'h4000, 16'h7BFF, 16'h7C00,
                            16'h3C00, 16'h8000, 16'h0401, 16'h7C00, 16'h0400, 16'h0400};
  logic        d_s [DN] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [19:0] d_e [DN] = '{20'h3C001, 20'h3C021, 20'h00000, 20'h00000, 20'h7C005, 20'h7E008,
                            20'h7E000, 20'h80000, 20'h80003, 20'hFC000, 20'h3C001, 20'h3C001};

  logic rnd_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a, b;
    int          base_acc, base_ret;
    rst_n = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b1;
    rnd_done = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_eq("reset_out_valid", 32'(out_valid), 32'd0);
    chk_eq("reset_result", 32'(result), 32'd0);
    chk_eq("reset_flags", 32'(flags), 32'd0);
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    @(negedge clock);
    chk_eq("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;

    // First op: 1.0 + 2.0 with the pipeline empty, latency measured.
    lat_chk(16'h3C00, 16'h4000, 1'b0, 20'h42000);

    for (int i = 0; i < DN; i++) send_d(d_a[i], d_b[i], d_s[i], d_e[i]);
    drain();

    // Backpressure: three ops fill the pipe, the rest wait until the sink is ready.
    out_ready = 1'b0;
    base_acc = n_acc; base_ret = n_ret;
    for (int i = 0; i < 3; i++) send(rnd_op(5'd15), rnd_op(5'd15), 1'($urandom));
    @(negedge clock);
    chk_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk_eq("bp_accepted", 32'(n_acc - base_acc), 32'd3);
    fork
      begin
        send(rnd_op(5'd15), rnd_op(5'd15), 1'($urandom));
        send(rnd_op(5'd15), rnd_op(5'd15), 1'($urandom));
      end
      begin
        repeat (4) @(negedge clock);
        chk_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        chk_eq("bp_hold_result", 32'(result), 32'(exp_q[0][19:4]));
        chk_eq("bp_stall_acc", 32'(n_acc - base_acc), 32'd3);
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk_eq("bp_retired", 32'(n_ret - base_ret), 32'd5);

    // Randomised traffic with random sink stalls.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          a = rnd_op(5'($urandom_range(1, 30)));
          b = ($urandom_range(0, 15) == 0) ? a : rnd_op(a[14:10]);
          send(a, b, 1'($urandom));
          repeat ($urandom_range(0, 1)) begin @(posedge clock); #1; end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Reset with three ops in flight: everything is discarded.
    for (int i = 0; i < 3; i++) send(rnd_op(5'd15), rnd_op(5'd15), 1'b0);
    chk_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_result", 32'(result), 32'd0);
    chk_eq("rst_flags", 32'(flags), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk_eq("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clock); #1;
    lat_chk(16'h3C00, 16'h4000, 1'b0, 20'h42000);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
